bank_isu_iq_mc: RTL
===================

# bank_isu_iq_mc

Parametrised issue queue for one cache bank, sitting between the hit/tag unit and the SRAM controller. It holds up to 2^PTR_WIDTH requests and issues one per cycle: the oldest eligible entry goes first. It gates issue on three things: linefill completion (MSHR wakeup), per-channel read credits held in internal counters for CH_NUM channels, and two-phase evict handling. It also frees entries in order from a bottom pointer.

## Interface
- PTR_WIDTH, 3: DEPTH = 2^PTR_WIDTH entries (PTR_WIDTH >= 1)
- CH_NUM, 3: number of response channels (2..4)
- CH_W, 2: channel id width, >= clog2(CH_NUM)
- CREDITS, 4: read credits per channel at reset (1..15)
- ROB_W, 3: xbar ROB id width

- clk_i  in  1  clock; single clock domain
- rst_i  in  1  reset; synchronous, active-high
- req_valid_i  in  1  enqueue request
- req_ready_o  out  1  queue not full
- req_opcode_i  in  2  bit0 = write, bit1 = evict first
- req_need_linefill_i  in  1  miss, wait for linefill
- req_inflight_i  in  1  hit on a line whose linefill is pending
- req_ch_id_i  in  CH_W  response channel
- req_rob_id_i  in  ROB_W  xbar ROB id
- req_set_way_offset_i  in  7  [6:1] = linefill id, [0] = offset
- req_wbuffer_id_i  in  8  write buffer id
- req_state_i  in  4  {offset1 state, offset0 state}
- lf_valid_i  in  1  linefill data arrived
- lf_id_i  in  6  linefill id
- iss_valid_o  out  1  issue request to SRAM controller
- iss_ready_i  in  1  SRAM controller accepts
- iss_opcode_o  out  2  0 write, 1 read, 2 read+linefill, 3 write-back
- iss_ch_id_o, iss_rob_id_o, iss_set_way_offset_o, iss_wbuffer_id_o, iss_state_o  out  CH_W/ROB_W/7/8/4  payload of the selected entry
- credit_release_i  in  CH_NUM  per-channel one-credit return
- count_o  out  PTR_WIDTH+1  occupied entries, bottom to write pointer

## Operation
- Enqueue: fires when req_valid_i & req_ready_o, writing entry wr_ptr.
  - Sets valid = 1.
  - Sets evict_pend = opcode[1].
  - Sets mshr_ok = ~(need_linefill | inflight), or 1 if lf_valid_i & lf_id_i == req_set_way_offset_i[6:1] in the same cycle.
  - wr_ptr then increments with natural wrap.
- MSHR wakeup: each cycle, every valid entry with set_way_offset[6:1] == lf_id_i while lf_valid_i sets mshr_ok. It is never cleared except by re-enqueue.
- Credits: one counter per channel, reset to CREDITS.
  - A read issue (opcode 1 or 2) decrements the counter of its channel.
  - credit_release_i[c] increments counter c.
  - Decrement and increment in the same cycle leave the counter unchanged.
  - A release at CREDITS is ignored (saturate).
- Eligible entry = valid & (evict_pend | (mshr_ok & (write | credit[ch] != 0))).
- Select: the first eligible entry scanning circularly from bottom_ptr. iss_valid_o = any eligible.
- Opcode: evict_pend → 3; else write → 0; else need_linefill → 2; else 1.
- On issue (iss_valid_o & iss_ready_i):
  - If evict_pend was set, clear evict_pend and keep valid. The entry re-arbitrates as its normal op from the next cycle.
  - Otherwise clear valid.
- Dequeue: when count != 0 & ~valid[bottom_ptr], bottom_ptr increments, at most one per cycle.
- count_o: +1 on enqueue, −1 on dequeue; unchanged when both happen. req_ready_o = count_o != DEPTH.
- A slot is reused only after bottom_ptr passes it. An issued but not yet dequeued entry blocks enqueue when full.

## Timing
- Reset, synchronous:
  - count_o = 0, req_ready_o = 1, iss_valid_o = 0.
  - All pointers, valid, evict_pend and mshr_ok = 0.
  - Payload arrays = 0, so all iss_* payload outputs read 0.
  - Credits = CREDITS.
  - Reset asserted mid-operation discards all entries and credits in that cycle.
- iss_* outputs are combinational from registered state only. There is no combinational path from req_* or lf_* to iss_*.
- Enqueue at edge N: the entry can issue in cycle N+1 at the earliest.
- Linefill wakeup at edge N: the entry can issue in cycle N+1.
- Issue at edge N:
  - That entry's valid drops after edge N.
  - It is dequeued at edge N+1 if it is at bottom.
  - The credit decrement is visible in cycle N+1.
- iss_valid_o may drop without a handshake if eligibility changes. The SRAM controller samples only on the handshake.
- Full, with a dequeue in the same cycle: req_ready_o stays 0 that cycle, because it comes from the registered count.

## Test plan
- Reset, then enqueue 8 reads (hit, not inflight) on channel 0 with CREDITS = 4 → exactly 4 issue with opcode 1 in order 0..3; iss_valid_o = 0. Pulse credit_release_i[0] twice → entries 4 and 5 issue.
- Fill 8 entries, hold iss_ready_i = 0 → req_ready_o = 0, count_o = 8. Issue entry 0 → count_o = 7 two cycles later, req_ready_o = 1.
- Enqueue a miss with id 5, then a hit behind it → the hit issues first. Pulse lf_valid_i with lf_id_i = 5 → the miss issues next cycle with opcode 2.
- Enqueue with opcode 2'b11 → issues opcode 3, stays valid, then issues opcode 0. Only then does count_o decrement.
- Same-cycle enqueue of a miss (id 9) and lf_valid_i with id 9 → issues next cycle. Same-cycle credit release and read issue on one channel → counter unchanged.
- Run enqueue/issue for more than 3×DEPTH entries with wrap; assert rst_i mid-stream → all outputs return to their reset values next cycle.

Source files
------------

// File: rtl/bank_isu_iq_mc_if.sv
// Request, linefill, issue and credit signals of the bank issue queue, named from the queue's side.
// The queue connects through the slave modport and the upstream/downstream driver through the master modport.
interface bank_isu_iq_mc_if #(
  parameter int PTR_WIDTH = 3,
  parameter int CH_NUM    = 3,
  parameter int CH_W      = 2,
  parameter int ROB_W     = 3
);
  logic                 req_valid_i;
  logic                 req_ready_o;
  logic [1:0]           req_opcode_i;
  logic                 req_need_linefill_i;
  logic                 req_inflight_i;
  logic [CH_W-1:0]      req_ch_id_i;
  logic [ROB_W-1:0]     req_rob_id_i;
  logic [6:0]           req_set_way_offset_i;
  logic [7:0]           req_wbuffer_id_i;
  logic [3:0]           req_state_i;
  logic                 lf_valid_i;
  logic [5:0]           lf_id_i;
  logic                 iss_valid_o;
  logic                 iss_ready_i;
  logic [1:0]           iss_opcode_o;
  logic [CH_W-1:0]      iss_ch_id_o;
  logic [ROB_W-1:0]     iss_rob_id_o;
  logic [6:0]           iss_set_way_offset_o;
  logic [7:0]           iss_wbuffer_id_o;
  logic [3:0]           iss_state_o;
  logic [CH_NUM-1:0]    credit_release_i;
  logic [PTR_WIDTH:0]   count_o;

  modport slave (
    input  req_valid_i, req_opcode_i, req_need_linefill_i, req_inflight_i, req_ch_id_i,
           req_rob_id_i, req_set_way_offset_i, req_wbuffer_id_i, req_state_i,
           lf_valid_i, lf_id_i, iss_ready_i, credit_release_i,
    output req_ready_o, iss_valid_o, iss_opcode_o, iss_ch_id_o, iss_rob_id_o,
           iss_set_way_offset_o, iss_wbuffer_id_o, iss_state_o, count_o
  );

  modport master (
    output req_valid_i, req_opcode_i, req_need_linefill_i, req_inflight_i, req_ch_id_i,
           req_rob_id_i, req_set_way_offset_i, req_wbuffer_id_i, req_state_i,
           lf_valid_i, lf_id_i, iss_ready_i, credit_release_i,
    input  req_ready_o, iss_valid_o, iss_opcode_o, iss_ch_id_o, iss_rob_id_o,
           iss_set_way_offset_o, iss_wbuffer_id_o, iss_state_o, count_o
  );
endinterface

// File: rtl/bank_isu_iq_mc.sv
// Cache-bank issue queue: oldest-eligible issue gated by linefill wakeup, per-channel read credits
// and two-phase evict; entries are freed in order from the bottom pointer.
module bank_isu_iq_mc #(
  parameter int PTR_WIDTH = 3,
  parameter int CH_NUM    = 3,
  parameter int CH_W      = 2,
  parameter int CREDITS   = 4,
  parameter int ROB_W     = 3
) (
  input logic                clk_i,
  input logic                rst_i,
  bank_isu_iq_mc_if.slave    bus
);
  localparam int DEPTH = 1 << PTR_WIDTH;
  typedef logic [PTR_WIDTH-1:0] ptr_t;

  logic [DEPTH-1:0]   r_valid, r_evictPend, r_mshrOk, r_write, r_needLf;
  logic [CH_W-1:0]    r_ch    [DEPTH];
  logic [ROB_W-1:0]   r_rob   [DEPTH];
  logic [6:0]         r_swo   [DEPTH];
  logic [7:0]         r_wbuf  [DEPTH];
  logic [3:0]         r_state [DEPTH];
  logic [3:0]         r_credit [CH_NUM];
  ptr_t               r_wrPtr, r_botPtr;
  logic [PTR_WIDTH:0] r_count;

  logic [DEPTH-1:0]   w_hasCredit, w_elig;
  logic [CH_NUM-1:0]  w_creditDec;
  ptr_t               w_sel;
  logic               w_any, w_issFire, w_readIss, w_enq, w_deq, w_enqLfHit;

  // A channel id outside 0..CH_NUM-1 never finds a counter, so such reads never issue.
  always_comb begin
    w_hasCredit = '0;
    for (int i = 0; i < DEPTH; i++) begin
      for (int c = 0; c < CH_NUM; c++) begin
        if (r_ch[i] == CH_W'(c) && r_credit[c] != 4'd0) w_hasCredit[i] = 1'b1;
      end
    end
    w_elig = r_valid & (r_evictPend | (r_mshrOk & (r_write | w_hasCredit)));
  end

  always_comb begin
    w_sel = r_botPtr;
    w_any = 1'b0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (w_elig[r_botPtr + ptr_t'(k)]) begin
        w_sel = r_botPtr + ptr_t'(k);
        w_any = 1'b1;
      end
    end
  end

  always_comb begin
    if (r_evictPend[w_sel])  bus.iss_opcode_o = 2'd3;
    else if (r_write[w_sel]) bus.iss_opcode_o = 2'd0;
    else if (r_needLf[w_sel]) bus.iss_opcode_o = 2'd2;
    else                     bus.iss_opcode_o = 2'd1;
  end

  assign bus.iss_valid_o          = w_any;
  assign bus.iss_ch_id_o          = r_ch[w_sel];
  assign bus.iss_rob_id_o         = r_rob[w_sel];
  assign bus.iss_set_way_offset_o = r_swo[w_sel];
  assign bus.iss_wbuffer_id_o     = r_wbuf[w_sel];
  assign bus.iss_state_o          = r_state[w_sel];
  assign bus.count_o              = r_count;
  assign bus.req_ready_o          = (r_count != (PTR_WIDTH+1)'(DEPTH));

  assign w_issFire  = w_any & bus.iss_ready_i;
  assign w_readIss  = w_issFire & ~r_evictPend[w_sel] & ~r_write[w_sel];
  assign w_enq      = bus.req_valid_i & bus.req_ready_o;
  assign w_deq      = (r_count != '0) & ~r_valid[r_botPtr];
  assign w_enqLfHit = bus.lf_valid_i & (bus.lf_id_i == bus.req_set_way_offset_i[6:1]);

  always_comb begin
    w_creditDec = '0;
    for (int c = 0; c < CH_NUM; c++) begin
      w_creditDec[c] = w_readIss && (r_ch[w_sel] == CH_W'(c));
    end
  end

  // The slot at wr_ptr is always free, so enqueue never collides with wakeup or issue updates.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_valid     <= '0;
      r_evictPend <= '0;
      r_mshrOk    <= '0;
      r_write     <= '0;
      r_needLf    <= '0;
      r_wrPtr     <= '0;
      r_botPtr    <= '0;
      r_count     <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_ch[i]    <= '0;
        r_rob[i]   <= '0;
        r_swo[i]   <= '0;
        r_wbuf[i]  <= '0;
        r_state[i] <= '0;
      end
      for (int c = 0; c < CH_NUM; c++) r_credit[c] <= 4'(CREDITS);
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (bus.lf_valid_i && r_valid[i] && r_swo[i][6:1] == bus.lf_id_i) r_mshrOk[i] <= 1'b1;
      end
      if (w_issFire) begin
        if (r_evictPend[w_sel]) r_evictPend[w_sel] <= 1'b0;
        else                    r_valid[w_sel]     <= 1'b0;
      end
      if (w_enq) begin
        r_valid[r_wrPtr]     <= 1'b1;
        r_evictPend[r_wrPtr] <= bus.req_opcode_i[1];
        r_write[r_wrPtr]     <= bus.req_opcode_i[0];
        r_needLf[r_wrPtr]    <= bus.req_need_linefill_i;
        r_mshrOk[r_wrPtr]    <= ~(bus.req_need_linefill_i | bus.req_inflight_i) | w_enqLfHit;
        r_ch[r_wrPtr]        <= bus.req_ch_id_i;
        r_rob[r_wrPtr]       <= bus.req_rob_id_i;
        r_swo[r_wrPtr]       <= bus.req_set_way_offset_i;
        r_wbuf[r_wrPtr]      <= bus.req_wbuffer_id_i;
        r_state[r_wrPtr]     <= bus.req_state_i;
        r_wrPtr              <= r_wrPtr + ptr_t'(1);
      end
      if (w_deq) r_botPtr <= r_botPtr + ptr_t'(1);
      case ({w_enq, w_deq})
        2'b10:   r_count <= r_count + (PTR_WIDTH+1)'(1);
        2'b01:   r_count <= r_count - (PTR_WIDTH+1)'(1);
        default: r_count <= r_count;
      endcase
      for (int c = 0; c < CH_NUM; c++) begin
        if (w_creditDec[c] && !bus.credit_release_i[c])
          r_credit[c] <= r_credit[c] - 4'd1;
        else if (!w_creditDec[c] && bus.credit_release_i[c] && r_credit[c] != 4'(CREDITS))
          r_credit[c] <= r_credit[c] + 4'd1;
      end
    end
  end
endmodule
